// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache between the CPU load/store stage and 128-bit block memory.
// Optional hit/miss statistics counters are enabled with `define DCACHE_STATS_EN.
module dcache_direct_mapped #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CPU_READ,
    input  logic         CPU_WRITE,
    input  logic [31:0]  CPU_ADDRESS,
    input  logic [31:0]  CPU_WRITEDATA,
    output logic [31:0]  CPU_READDATA,
    output logic         CPU_BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]  HIT_COUNT,
    output logic [15:0]  MISS_COUNT
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    state_t state, next_state;
    logic   issued;

    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [127:0]     data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      req_tag;
    logic [1:0]            word_sel;
    logic                  addr_unused;

    assign idx         = CPU_ADDRESS[3+INDEX_BITS:4];
    assign req_tag     = CPU_ADDRESS[31:4+INDEX_BITS];
    assign word_sel    = CPU_ADDRESS[3:2];
    assign addr_unused = ^CPU_ADDRESS[1:0];

    logic req_valid, hit, write_hit, wb_done, fill_done;

    assign req_valid = CPU_READ ^ CPU_WRITE;
    assign hit       = valid[idx] && (tag_mem[idx] == req_tag);
    assign write_hit = (state == IDLE) && CPU_WRITE && !CPU_READ && hit;
    assign wb_done   = (state == WRITEBACK) && issued && !MEM_BUSYWAIT;
    assign fill_done = (state == FETCH) && issued && !MEM_BUSYWAIT;

    always_comb begin
        next_state    = state;
        CPU_READDATA  = data_mem[idx][{word_sel, 5'b00000} +: 32];
        CPU_BUSYWAIT  = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (state)
            IDLE: begin
                if (req_valid && !hit) begin
                    CPU_BUSYWAIT = 1'b1;
                    next_state   = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                CPU_BUSYWAIT  = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_mem[idx], idx};
                MEM_WRITEDATA = data_mem[idx];
                if (wb_done) next_state = FETCH;
            end
            FETCH: begin
                CPU_BUSYWAIT = 1'b1;
                MEM_READ     = 1'b1;
                MEM_ADDRESS  = {req_tag, idx};
                if (fill_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Control state: FSM, handshake flag, per-line valid/dirty bits.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            issued <= 1'b0;
            valid  <= '0;
            dirty  <= '0;
        end else begin
            state  <= next_state;
            issued <= (next_state != state) ? 1'b0 : (state != IDLE);
            if (write_hit) dirty[idx] <= 1'b1;
            if (wb_done)   dirty[idx] <= 1'b0;
            if (fill_done) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end

    // Line storage is never cleared; writes are suppressed while reset is asserted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (write_hit) data_mem[idx][{word_sel, 5'b00000} +: 32] <= CPU_WRITEDATA;
            if (fill_done) begin
                data_mem[idx] <= MEM_READDATA;
                tag_mem[idx]  <= req_tag;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic post_fill;
    logic hit_inc, miss_inc;

    // The request that caused a fill hits on the cycle after FETCH; it is not a fresh hit.
    assign hit_inc  = (state == IDLE) && req_valid && hit && !post_fill;
    assign miss_inc = (state == IDLE) && (next_state != IDLE);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            post_fill  <= 1'b0;
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            post_fill <= fill_done;
            if (hit_inc && HIT_COUNT != 16'hFFFF)   HIT_COUNT  <= HIT_COUNT + 16'd1;
            if (miss_inc && MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed self-checking bench for dcache_direct_mapped (8 lines); checks counters when DCACHE_STATS_EN is defined.
module tb_dcache_direct_mapped;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         CPU_READ, CPU_WRITE;
    logic [31:0]  CPU_ADDRESS, CPU_WRITEDATA, CPU_READDATA;
    logic         CPU_BUSYWAIT;
    logic         MEM_READ, MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA, MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [15:0]  HIT_COUNT, MISS_COUNT;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    dcache_direct_mapped #(.INDEX_BITS(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_READ(CPU_READ), .CPU_WRITE(CPU_WRITE),
        .CPU_ADDRESS(CPU_ADDRESS), .CPU_WRITEDATA(CPU_WRITEDATA),
        .CPU_READDATA(CPU_READDATA), .CPU_BUSYWAIT(CPU_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
    );

    // Inputs change and outputs are sampled 1 time unit after the falling edge.
    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0; CPU_READ = 1'b0; CPU_WRITE = 1'b0;
        CPU_ADDRESS = '0; CPU_WRITEDATA = '0;
        MEM_READDATA = '0; MEM_BUSYWAIT = 1'b0;
        cyc(); cyc();
        total++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
            bad++; $display("FAIL reset_mem_req: rd=%b wr=%b want 0 0", MEM_READ, MEM_WRITE);
        end
        total++; if (CPU_BUSYWAIT !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b want 0", CPU_BUSYWAIT);
        end
        total++; if (MEM_ADDRESS !== 28'h0 || MEM_WRITEDATA !== 128'h0) begin
            bad++; $display("FAIL reset_mem_bus: addr=%h data=%h want 0", MEM_ADDRESS, MEM_WRITEDATA);
        end
`ifdef DCACHE_STATS_EN
        total++; if (HIT_COUNT !== 16'd0 || MISS_COUNT !== 16'd0) begin
            bad++; $display("FAIL reset_counters: hit=%0d miss=%0d want 0 0", HIT_COUNT, MISS_COUNT);
        end
`endif
        RESET = 1'b1;
        cyc();
    endtask

    task automatic test_read_miss_fill();
        int n;
        logic saw_wr;
        MEM_READDATA = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111};
        MEM_BUSYWAIT = 1'b0;
        CPU_READ = 1'b1; CPU_ADDRESS = 32'h00000014;
        #1;
        total++; if (CPU_BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0) begin
            bad++; $display("FAIL miss_detect: busy=%b memrd=%b want 1 0", CPU_BUSYWAIT, MEM_READ);
        end
        cyc();
        total++; if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== 28'h0000001) begin
            bad++; $display("FAIL fetch_req: rd=%b wr=%b addr=%h want 1 0 0000001", MEM_READ, MEM_WRITE, MEM_ADDRESS);
        end
        saw_wr = 1'b0;
        n = 0;
        while (CPU_BUSYWAIT === 1'b1 && n < 20) begin
            if (MEM_WRITE === 1'b1) saw_wr = 1'b1;
            cyc();
            n++;
        end
        total++; if (n !== 2) begin
            bad++; $display("FAIL fill_latency: got %0d cycles want 2", n);
        end
        total++; if (CPU_READDATA !== 32'hDEADBEEF) begin
            bad++; $display("FAIL fill_data: got %h want deadbeef", CPU_READDATA);
        end
        total++; if (saw_wr !== 1'b0) begin
            bad++; $display("FAIL clean_no_writeback: got %b want 0", saw_wr);
        end
        CPU_READ = 1'b0;
        cyc();
    endtask

    task automatic test_read_hit();
        CPU_READ = 1'b1; CPU_ADDRESS = 32'h00000018;
        #1;
        total++; if (CPU_BUSYWAIT !== 1'b0 || CPU_READDATA !== 32'h33333333) begin
            bad++; $display("FAIL read_hit: busy=%b data=%h want 0 33333333", CPU_BUSYWAIT, CPU_READDATA);
        end
        cyc();
        total++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
            bad++; $display("FAIL read_hit_nomem: rd=%b wr=%b want 0 0", MEM_READ, MEM_WRITE);
        end
        CPU_READ = 1'b0;
        cyc();
    endtask

    task automatic test_write_hit_writeback();
        int n;
        logic both;
        CPU_WRITE = 1'b1; CPU_ADDRESS = 32'h00000014; CPU_WRITEDATA = 32'h12345678;
        #1;
        total++; if (CPU_BUSYWAIT !== 1'b0) begin
            bad++; $display("FAIL write_hit_busy: got %b want 0", CPU_BUSYWAIT);
        end
        cyc();
        CPU_WRITE = 1'b0;
        #1;
        total++; if (CPU_READDATA !== 32'h12345678) begin
            bad++; $display("FAIL write_hit_word: got %h want 12345678", CPU_READDATA);
        end
        CPU_ADDRESS = 32'h00000010;
        #1;
        total++; if (CPU_READDATA !== 32'h11111111) begin
            bad++; $display("FAIL write_hit_neighbour: got %h want 11111111", CPU_READDATA);
        end
        MEM_READDATA = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hCAFEF00D, 32'hA0A0A0A0};
        CPU_READ = 1'b1; CPU_ADDRESS = 32'h00000094;
        #1;
        total++; if (CPU_BUSYWAIT !== 1'b1) begin
            bad++; $display("FAIL dirty_miss_busy: got %b want 1", CPU_BUSYWAIT);
        end
        cyc();
        total++; if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0 || MEM_ADDRESS !== 28'h0000001) begin
            bad++; $display("FAIL wb_req: wr=%b rd=%b addr=%h want 1 0 0000001", MEM_WRITE, MEM_READ, MEM_ADDRESS);
        end
        total++; if (MEM_WRITEDATA !== {32'h44444444, 32'h33333333, 32'h12345678, 32'h11111111}) begin
            bad++; $display("FAIL wb_data: got %h want 44444444333333331234567811111111", MEM_WRITEDATA);
        end
        both = 1'b0;
        n = 0;
        while (MEM_READ !== 1'b1 && n < 20) begin
            if (MEM_READ === 1'b1 && MEM_WRITE === 1'b1) both = 1'b1;
            cyc();
            n++;
        end
        total++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 28'h0000009) begin
            bad++; $display("FAIL refill_req: rd=%b addr=%h want 1 0000009", MEM_READ, MEM_ADDRESS);
        end
        n = 0;
        while (CPU_BUSYWAIT === 1'b1 && n < 20) begin
            if (MEM_READ === 1'b1 && MEM_WRITE === 1'b1) both = 1'b1;
            cyc();
            n++;
        end
        total++; if (CPU_BUSYWAIT !== 1'b0 || CPU_READDATA !== 32'hCAFEF00D) begin
            bad++; $display("FAIL refill_data: busy=%b data=%h want 0 cafef00d", CPU_BUSYWAIT, CPU_READDATA);
        end
        total++; if (both !== 1'b0) begin
            bad++; $display("FAIL mem_exclusive: got %b want 0", both);
        end
        CPU_READ = 1'b0;
        cyc();
    endtask

    task automatic test_both_high();
        CPU_READ = 1'b1; CPU_WRITE = 1'b1;
        CPU_ADDRESS = 32'h00000094; CPU_WRITEDATA = 32'hBAD0BAD0;
        #1;
        total++; if (CPU_BUSYWAIT !== 1'b0) begin
            bad++; $display("FAIL both_high_busy: got %b want 0", CPU_BUSYWAIT);
        end
        cyc(); cyc();
        total++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0 || CPU_BUSYWAIT !== 1'b0) begin
            bad++; $display("FAIL both_high_idle: rd=%b wr=%b busy=%b want 0 0 0", MEM_READ, MEM_WRITE, CPU_BUSYWAIT);
        end
        CPU_READ = 1'b0; CPU_WRITE = 1'b0;
        #1;
        total++; if (CPU_READDATA !== 32'hCAFEF00D) begin
            bad++; $display("FAIL both_high_nowrite: got %h want cafef00d", CPU_READDATA);
        end
`ifdef DCACHE_STATS_EN
        total++; if (HIT_COUNT !== 16'd2 || MISS_COUNT !== 16'd2) begin
            bad++; $display("FAIL stats_counts: hit=%0d miss=%0d want 2 2", HIT_COUNT, MISS_COUNT);
        end
`endif
        cyc();
    endtask

    task automatic test_reset_mid_fetch();
        int n;
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = {32'h0, 32'h0, 32'h0, 32'h55AA55AA};
        CPU_READ = 1'b1; CPU_ADDRESS = 32'h00000400;
        cyc();
        total++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 28'h0000040) begin
            bad++; $display("FAIL midfetch_req: rd=%b addr=%h want 1 0000040", MEM_READ, MEM_ADDRESS);
        end
        cyc();
        RESET = 1'b0;
        cyc();
        total++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
            bad++; $display("FAIL midfetch_abort: rd=%b wr=%b want 0 0", MEM_READ, MEM_WRITE);
        end
`ifdef DCACHE_STATS_EN
        total++; if (HIT_COUNT !== 16'd0 || MISS_COUNT !== 16'd0) begin
            bad++; $display("FAIL stats_cleared: hit=%0d miss=%0d want 0 0", HIT_COUNT, MISS_COUNT);
        end
`endif
        CPU_READ = 1'b0;
        RESET = 1'b1;
        cyc();
        CPU_READ = 1'b1; CPU_ADDRESS = 32'h00000400;
        #1;
        total++; if (CPU_BUSYWAIT !== 1'b1) begin
            bad++; $display("FAIL remiss_after_reset: got %b want 1", CPU_BUSYWAIT);
        end
        CPU_ADDRESS = 32'h00000094;
        #1;
        total++; if (CPU_BUSYWAIT !== 1'b1) begin
            bad++; $display("FAIL valid_cleared: got %b want 1", CPU_BUSYWAIT);
        end
        CPU_ADDRESS = 32'h00000400;
        MEM_BUSYWAIT = 1'b0;
        n = 0;
        cyc();
        while (CPU_BUSYWAIT === 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        total++; if (CPU_BUSYWAIT !== 1'b0 || CPU_READDATA !== 32'h55AA55AA) begin
            bad++; $display("FAIL post_reset_fill: busy=%b data=%h want 0 55aa55aa", CPU_BUSYWAIT, CPU_READDATA);
        end
        CPU_READ = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_read_miss_fill();
        test_read_hit();
        test_write_hit_writeback();
        test_both_high();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
